// File: rtl/fsmd_datapath.sv
// FSMD datapath: 8-entry register file, combinational ALU with N/Z flags,
// and a strobed result capture register for an external controller.
package fsmd_pkg;

    typedef logic [2:0] rsel_t;

    typedef enum logic {
        DSEL_ALU = 1'b0,
        DSEL_EXT = 1'b1
    } dsel_t;

    typedef enum logic [2:0] {
        FN_MOVA = 3'd0,
        FN_INC  = 3'd1,
        FN_ADD  = 3'd2,
        FN_MUL  = 3'd3,
        FN_AND  = 3'd4,
        FN_CLR  = 3'd5
    } alufunc_t;

endpackage

module fsmd_datapath
    import fsmd_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          srst_n,
    input  logic          we_in,
    input  rsel_t         rsel_in,
    input  rsel_t         asel_in,
    input  rsel_t         bsel_in,
    input  dsel_t         dsel_in,
    input  alufunc_t      fsel_in,
    input  logic [DW-1:0] ext_in,
    input  logic          done_in,
    output logic          n_out,
    output logic          z_out,
    output logic [DW-1:0] result_out,
    output logic          valid_out
);

    logic [DW-1:0]   regs [8];
    logic [DW-1:0]   a_op;
    logic [DW-1:0]   b_op;
    logic [DW-1:0]   alu_f;
    logic [2*DW-1:0] prod;
    logic [DW-1:0]   wdata;
    logic [DW-1:0]   result_q;
    logic            valid_q;

    // Independent operand reads; pre-edge values, so writes show next cycle.
    always_comb begin
        a_op = regs[asel_in];
        b_op = regs[bsel_in];
    end

    // ALU; undefined function codes pass operand A through.
    always_comb begin
        prod  = {{DW{1'b0}}, a_op} * {{DW{1'b0}}, b_op};
        alu_f = a_op;
        unique case (fsel_in)
            FN_MOVA: alu_f = a_op;
            FN_INC:  alu_f = a_op + DW'(1);
            FN_ADD:  alu_f = a_op + b_op;
            FN_MUL:  alu_f = prod[DW-1:0];
            FN_AND:  alu_f = a_op & b_op;
            FN_CLR:  alu_f = '0;
            default: alu_f = a_op;
        endcase
    end

    // Flags follow the live ALU result so the controller can branch this cycle.
    always_comb begin
        n_out = alu_f[DW-1];
        z_out = (alu_f == '0);
    end

    // Write-data source mux.
    always_comb begin
        wdata = alu_f;
        if (dsel_in == DSEL_EXT) begin
            wdata = ext_in;
        end
    end

    // Register file update; reset clears every entry and wins over a write.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (we_in) begin
            regs[rsel_in] <= wdata;
        end
    end

    // Result capture of operand B with a one-cycle valid pulse.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= done_in;
            if (done_in) begin
                result_q <= b_op;
            end
        end
    end

    assign result_out = result_q;
    assign valid_out  = valid_q;

endmodule

// File: tb/tb_fsmd_datapath.sv
// Directed self-checking bench for fsmd_datapath (DW = 8).
// Register contents are observed through the B-port capture path.
module tb_fsmd_datapath;
    import fsmd_pkg::*;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          srst_n;
    logic          we_in;
    rsel_t         rsel_in;
    rsel_t         asel_in;
    rsel_t         bsel_in;
    dsel_t         dsel_in;
    alufunc_t      fsel_in;
    logic [DW-1:0] ext_in;
    logic          done_in;
    logic          n_out;
    logic          z_out;
    logic [DW-1:0] result_out;
    logic          valid_out;

    int checks = 0;
    int errors = 0;

    fsmd_datapath #(.DW(DW)) dut (
        .clk        (clk),
        .srst_n     (srst_n),
        .we_in      (we_in),
        .rsel_in    (rsel_in),
        .asel_in    (asel_in),
        .bsel_in    (bsel_in),
        .dsel_in    (dsel_in),
        .fsel_in    (fsel_in),
        .ext_in     (ext_in),
        .done_in    (done_in),
        .n_out      (n_out),
        .z_out      (z_out),
        .result_out (result_out),
        .valid_out  (valid_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic write_ext(input rsel_t r, input logic [DW-1:0] v);
        we_in   = 1'b1;
        rsel_in = r;
        dsel_in = DSEL_EXT;
        ext_in  = v;
        step();
        we_in   = 1'b0;
        dsel_in = DSEL_ALU;
    endtask

    task automatic alu_op(input alufunc_t f, input rsel_t a, input rsel_t b,
                          input rsel_t d, input logic we);
        fsel_in = f;
        asel_in = a;
        bsel_in = b;
        rsel_in = d;
        dsel_in = DSEL_ALU;
        we_in   = we;
        settle();
    endtask

    task automatic peek(input string tag, input rsel_t r,
                        input logic [DW-1:0] exp);
        bsel_in = r;
        done_in = 1'b1;
        step();
        done_in = 1'b0;
        chk({tag, "_res"}, result_out, exp);
        chk({tag, "_vld"}, {7'd0, valid_out}, 8'd1);
        step();
        chk({tag, "_vld0"}, {7'd0, valid_out}, 8'd0);
    endtask

    initial begin
        srst_n  = 1'b0;
        we_in   = 1'b0;
        rsel_in = '0;
        asel_in = '0;
        bsel_in = '0;
        dsel_in = DSEL_ALU;
        fsel_in = FN_MOVA;
        ext_in  = '0;
        done_in = 1'b0;

        // reset then sweep
        step();
        srst_n = 1'b1;
        chk("rst_res", result_out, 8'h00);
        chk("rst_vld", {7'd0, valid_out}, 8'd0);
        for (int i = 0; i < 8; i++) begin
            alu_op(FN_MOVA, rsel_t'(i), 3'd0, 3'd0, 1'b0);
            chk($sformatf("rst_z%0d", i), {7'd0, z_out}, 8'd1);
            chk($sformatf("rst_n%0d", i), {7'd0, n_out}, 8'd0);
        end
        chk("rst_r0_dyn", {7'd0, (z_out && !n_out)}, 8'd1);

        // load and add
        write_ext(3'd1, 8'h12);
        write_ext(3'd2, 8'h34);
        alu_op(FN_ADD, 3'd1, 3'd2, 3'd4, 1'b1);
        chk("add_n", {7'd0, n_out}, 8'd0);
        chk("add_z", {7'd0, z_out}, 8'd0);
        step();
        we_in = 1'b0;
        alu_op(FN_MOVA, 3'd4, 3'd0, 3'd0, 1'b0);
        chk("mova_r4_z", {7'd0, z_out}, 8'd0);
        peek("add_r4", 3'd4, 8'h46);

        // AND
        alu_op(FN_AND, 3'd1, 3'd2, 3'd6, 1'b1);
        chk("and_z", {7'd0, z_out}, 8'd0);
        step();
        we_in = 1'b0;
        peek("and_r6", 3'd6, 8'h10);

        // multiply truncation
        write_ext(3'd3, 8'h10);
        write_ext(3'd4, 8'h20);
        alu_op(FN_MUL, 3'd3, 3'd4, 3'd5, 1'b1);
        chk("mul0_z", {7'd0, z_out}, 8'd1);
        step();
        we_in = 1'b0;
        peek("mul0_r5", 3'd5, 8'h00);
        write_ext(3'd3, 8'h0F);
        write_ext(3'd4, 8'h11);
        alu_op(FN_MUL, 3'd3, 3'd4, 3'd5, 1'b1);
        chk("mul1_n", {7'd0, n_out}, 8'd1);
        chk("mul1_z", {7'd0, z_out}, 8'd0);
        step();
        we_in = 1'b0;
        peek("mul1_r5", 3'd5, 8'hFF);

        // ADD carry discarded
        write_ext(3'd6, 8'hF0);
        write_ext(3'd7, 8'h20);
        alu_op(FN_ADD, 3'd6, 3'd7, 3'd6, 1'b1);
        chk("addc_n", {7'd0, n_out}, 8'd0);
        step();
        we_in = 1'b0;
        peek("addc_r6", 3'd6, 8'h10);

        // INC with destination == source, B reads old value
        write_ext(3'd0, 8'hFF);
        alu_op(FN_INC, 3'd0, 3'd0, 3'd0, 1'b1);
        done_in = 1'b1;
        chk("inc_z", {7'd0, z_out}, 8'd1);
        step();
        we_in   = 1'b0;
        done_in = 1'b0;
        chk("inc_bold", result_out, 8'hFF);
        chk("inc_bvld", {7'd0, valid_out}, 8'd1);
        peek("inc_r0", 3'd0, 8'h00);
        write_ext(3'd0, 8'h7F);
        alu_op(FN_INC, 3'd0, 3'd0, 3'd0, 1'b0);
        chk("inc7f_n", {7'd0, n_out}, 8'd1);
        chk("inc7f_z", {7'd0, z_out}, 8'd0);
        step();
        peek("inc7f_r0", 3'd0, 8'h7F);

        // we_in = 0 blocks CLR write
        alu_op(FN_CLR, 3'd5, 3'd0, 3'd5, 1'b0);
        chk("clr_z", {7'd0, z_out}, 8'd1);
        step();
        peek("nowe_r5", 3'd5, 8'hFF);

        // undefined function code passes A
        write_ext(3'd5, 8'h5A);
        alu_op(alufunc_t'(3'd7), 3'd5, 3'd0, 3'd7, 1'b1);
        chk("fn7_n", {7'd0, n_out}, 8'd0);
        step();
        we_in = 1'b0;
        peek("fn7_r7", 3'd7, 8'h5A);

        // capture and back-to-back strobes
        peek("cap_r5", 3'd5, 8'h5A);
        bsel_in = 3'd1;
        done_in = 1'b1;
        step();
        chk("b2b_res0", result_out, 8'h12);
        chk("b2b_vld0", {7'd0, valid_out}, 8'd1);
        bsel_in = 3'd2;
        step();
        done_in = 1'b0;
        chk("b2b_res1", result_out, 8'h34);
        chk("b2b_vld1", {7'd0, valid_out}, 8'd1);
        step();
        chk("b2b_end", {7'd0, valid_out}, 8'd0);
        chk("b2b_hold", result_out, 8'h34);

        // reset collision
        srst_n  = 1'b0;
        we_in   = 1'b1;
        rsel_in = 3'd2;
        dsel_in = DSEL_EXT;
        ext_in  = 8'hAA;
        bsel_in = 3'd2;
        done_in = 1'b1;
        step();
        chk("col_res", result_out, 8'h00);
        chk("col_vld", {7'd0, valid_out}, 8'd0);
        srst_n  = 1'b1;
        we_in   = 1'b0;
        done_in = 1'b0;
        dsel_in = DSEL_ALU;
        alu_op(FN_MOVA, 3'd2, 3'd0, 3'd0, 1'b0);
        chk("col_r2_z", {7'd0, z_out}, 8'd1);
        alu_op(FN_MOVA, 3'd5, 3'd0, 3'd0, 1'b0);
        chk("col_r5_z", {7'd0, z_out}, 8'd1);
        peek("col_r2", 3'd2, 8'h00);
        peek("col_r7", 3'd7, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
